if_id_queue: RTL
================

Name: if_id_queue

Overview:
- Parametrised successor to the single-stage IF/ID pipeline register: a DEPTH-entry in-order queue between fetch and decode.
- Carries instruction, PC and stop flag per entry.
- Adds valid/ready handshakes on both sides, back-pressure, a flush for redirects, and a sticky stop that blocks fetch after the final instruction.
- Instantiated in place of the plain IF/ID register so decode stalls no longer lose fetched instructions.

Parameters:
INST_W, 32, instruction width in bits
PC_W, 32, PC width in bits
DEPTH, 4, queue entries; power of two, >= 2
CNT_W, $clog2(DEPTH+1), occupancy counter width (derived; do not override)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
flush  input  1  synchronous queue clear (redirect/mispredict)
in_valid  input  1  IF presents an entry
in_ready  output  1  queue accepts an entry this cycle
inst_in  input  INST_W  fetched instruction
pc_in  input  PC_W  PC of inst_in
stop_in  input  1  end-of-program marker for this entry
out_valid  output  1  head entry valid for ID
out_ready  input  1  ID consumes head this cycle
inst_out  output  INST_W  head instruction
pc_out  output  PC_W  head PC
stop_out  output  1  head stop flag
count  output  CNT_W  current occupancy, 0..DEPTH
stopped  output  1  a stop entry has been accepted since the last reset/flush

Behaviour:
- Reset (rst=1, async, any cycle incl. mid-operation): rd/wr pointers=0, count=0, stopped=0, all storage=0; out_valid=0, inst_out=0, pc_out=0, stop_out=0, in_ready=0 while rst is high.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = !rst & (count < DEPTH) & !stopped. It is not a function of out_ready, so there is no pass-through when full.
- out_valid = (count != 0).
- inst_out/pc_out/stop_out = head storage entry when out_valid=1; forced to 0 when empty.
- Latency: an entry pushed at edge N is visible on the outputs after edge N. There is no same-cycle bypass from inst_in to inst_out.
- push only: write at wr_ptr, wr_ptr+1, count+1.
- pop only: rd_ptr+1, count-1.
- Push and pop together: both pointers advance and count is unchanged. This is legal at any count 1..DEPTH-1. At count=DEPTH push cannot happen (in_ready=0).
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH naturally. Order is strictly FIFO.
- Stop: when a pushed entry has stop_in=1, stopped<=1 on that edge. No further pushes are accepted until flush/reset. Queued entries still drain normally. stop_out rises only when the stop entry reaches the head.
- flush=1 at an edge: count=0, pointers=0, stopped=0. The push and pop in that cycle are both discarded. Flush has priority over everything except rst.
- Storage contents after a flush are don't-care, but outputs read 0 because out_valid=0.
- Overflow and underflow are impossible by construction. Add an assertion that pop never occurs with count=0.

Test Plan:
- Reset then fill: rst pulse; push PC 0x0,0x4,0x8,0xC (inst 0x00000013+i) with out_ready=0 -> count=4, in_ready=0 after 4th edge; 5th in_valid ignored; out_valid=1, pc_out=0x0.
- Drain in order: from full, out_ready=1 for 4 cycles -> pc_out sequence 0x0,0x4,0x8,0xC, then out_valid=0, inst_out=0, count=0.
- Simultaneous push/pop with wrap: keep count=2, push and pop together for 10 cycles -> count stays 2; PCs exit in push order across the pointer wrap; no drop or duplicate.
- Flush priority: count=3, assert flush with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, pc_out=0; the entry pushed in the flush cycle never appears.
- Sticky stop: push A, B(stop_in=1), then C -> C refused (in_ready=0 after B); stopped=1; drain shows stop_out=0 for A and 1 for B; flush -> stopped=0, in_ready=1.
- Async reset mid-traffic: count=3, raise rst between edges -> outputs zero immediately without a clock edge; after release queue is empty and accepts pushes.

Source files
------------

// File: rtl/if_id_queue.sv
// In-order fetch-to-decode queue: DEPTH entries of {instruction, PC, stop flag}
// with valid/ready on both sides, redirect flush and a sticky end-of-program stop.
module if_id_queue #(
    parameter int INST_W = 32,
    parameter int PC_W   = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] inst_in,
    input  logic [PC_W-1:0]   pc_in,
    input  logic              stop_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] inst_out,
    output logic [PC_W-1:0]   pc_out,
    output logic              stop_out,
    output logic [CNT_W-1:0]  count,
    output logic              stopped
);

    localparam int              PTR_W  = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);

    logic [INST_W-1:0] inst_mem_q [DEPTH];
    logic [PC_W-1:0]   pc_mem_q   [DEPTH];
    logic              stop_mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             stopped_q, stopped_d;

    logic push, pop, wr_en;

    // in_ready ignores out_ready on purpose: no pass-through when full.
    assign in_ready  = !rst && (count_q < FULL_C) && !stopped_q;
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign inst_out = out_valid ? inst_mem_q[rd_ptr_q] : '0;
    assign pc_out   = out_valid ? pc_mem_q[rd_ptr_q]   : '0;
    assign stop_out = out_valid ? stop_mem_q[rd_ptr_q] : 1'b0;
    assign count    = count_q;
    assign stopped  = stopped_q;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        stopped_d = stopped_q;
        wr_en     = 1'b0;
        if (flush) begin
            // Redirect discards this cycle's push and pop along with the queue.
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            stopped_d = 1'b0;
        end else begin
            if (push) begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (stop_in) begin
                    stopped_d = 1'b1;
                end
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            stopped_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            stopped_q <= stopped_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                inst_mem_q[i] <= '0;
                pc_mem_q[i]   <= '0;
                stop_mem_q[i] <= 1'b0;
            end
        end else if (wr_en) begin
            inst_mem_q[wr_ptr_q] <= inst_in;
            pc_mem_q[wr_ptr_q]   <= pc_in;
            stop_mem_q[wr_ptr_q] <= stop_in;
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(pop && (count_q == '0)));
        end
    end
`endif

endmodule
